// File: rtl/main_fsm_if.sv
// Control bundle between the multi-cycle RV32I main FSM (master) and its datapath (slave).
interface main_fsm_if;
  logic [6:0] op;
  logic       pc_update;
  logic       branch;
  logic       ir_write;
  logic       reg_write;
  logic       mem_write;
  logic       adr_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] result_src;
  logic [1:0] imm_src;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  op,
    output pc_update, branch, ir_write, reg_write, mem_write, adr_src,
    output alu_src_a, alu_src_b, alu_op, result_src, imm_src, illegal_op, state
  );

  modport slave (
    output op,
    input  pc_update, branch, ir_write, reg_write, mem_write, adr_src,
    input  alu_src_a, alu_src_b, alu_op, result_src, imm_src, illegal_op, state
  );
endinterface

// File: rtl/main_fsm.sv
// Moore control FSM for the multi-cycle RV32I datapath (lw, sw, R, I, beq, jal).
// Define MAIN_FSM_ILLEGAL_TRAP_EN to trap unknown opcodes in a sticky ILLEGAL state.
module main_fsm (
  input  logic       clk,
  input  logic       reset,
  main_fsm_if.master bus
);

  localparam logic [6:0] OpLw   = 7'b0000011;
  localparam logic [6:0] OpSw   = 7'b0100011;
  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpI    = 7'b0010011;
  localparam logic [6:0] OpJal  = 7'b1101111;
  localparam logic [6:0] OpBeq  = 7'b1100011;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecuteR = 4'd6,
    StAluWb    = 4'd7,
    StExecuteI = 4'd8,
    StJal      = 4'd9,
    StBeq      = 4'd10,
    StIllegal  = 4'd11
  } state_e;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    logic       illegal;
`endif
  } ctrl_t;

  function automatic ctrl_t ctrl_of(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      StFetch: begin
        c.ir_write = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10; c.pc_update = 1'b1;
      end
      StDecode:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      StMemAdr:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      StMemRead:  c.adr_src = 1'b1;
      StMemWb:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
      StMemWrite: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
      StExecuteR: begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
      StExecuteI: begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
      StAluWb:    c.reg_write = 1'b1;
      StJal:      begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_update = 1'b1; end
      StBeq:      begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1'b1; end
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
      StIllegal:  c.illegal = 1'b1;
`endif
      default:    c = '0;
    endcase
    return c;
  endfunction

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        case (bus.op)
          OpLw, OpSw: state_d = StMemAdr;
          OpR:        state_d = StExecuteR;
          OpI:        state_d = StExecuteI;
          OpJal:      state_d = StJal;
          OpBeq:      state_d = StBeq;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
          default:    state_d = StIllegal;
`else
          default:    state_d = StFetch;
`endif
        endcase
      end
      StMemAdr:   state_d = (bus.op == OpSw) ? StMemWrite : StMemRead;
      StMemRead:  state_d = StMemWb;
      StExecuteR, StExecuteI, StJal: state_d = StAluWb;
      StMemWb, StMemWrite, StAluWb, StBeq: state_d = StFetch;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
      StIllegal:  state_d = StIllegal;
`endif
      default:    state_d = StFetch;
    endcase
    // Outputs are a pure function of the state they will accompany, so they register cleanly.
    ctrl_d = ctrl_of(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      ctrl_q  <= ctrl_of(StFetch);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  always_comb begin
    case (bus.op)
      OpSw:    bus.imm_src = 2'b01;
      OpBeq:   bus.imm_src = 2'b10;
      OpJal:   bus.imm_src = 2'b11;
      default: bus.imm_src = 2'b00;
    endcase
  end

  // Strobes are masked while reset is high so no write escapes during any reset cycle.
  assign bus.pc_update  = ctrl_q.pc_update & ~reset;
  assign bus.branch     = ctrl_q.branch    & ~reset;
  assign bus.ir_write   = ctrl_q.ir_write  & ~reset;
  assign bus.reg_write  = ctrl_q.reg_write & ~reset;
  assign bus.mem_write  = ctrl_q.mem_write & ~reset;
  assign bus.adr_src    = ctrl_q.adr_src;
  assign bus.alu_src_a  = ctrl_q.alu_src_a;
  assign bus.alu_src_b  = ctrl_q.alu_src_b;
  assign bus.alu_op     = ctrl_q.alu_op;
  assign bus.result_src = ctrl_q.result_src;
  assign bus.state      = state_q;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
  assign bus.illegal_op = ctrl_q.illegal & ~reset;
`else
  assign bus.illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_main_fsm.sv
// Self-checking bench for main_fsm: directed instructions plus random opcode streams.
module tb_main_fsm;
  localparam logic [6:0] Lw  = 7'b0000011;
  localparam logic [6:0] Sw  = 7'b0100011;
  localparam logic [6:0] Rt  = 7'b0110011;
  localparam logic [6:0] It  = 7'b0010011;
  localparam logic [6:0] Jal = 7'b1101111;
  localparam logic [6:0] Beq = 7'b1100011;

  logic clk = 1'b0;
  logic reset;
  int   npass = 0;
  int   ntotal = 0;

  main_fsm_if bus ();
  main_fsm dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  logic [14:0] obs;
  logic [4:0]  strobes;
  assign obs = {bus.pc_update, bus.branch, bus.ir_write, bus.reg_write, bus.mem_write,
                bus.adr_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.result_src,
                bus.illegal_op};
  assign strobes = {bus.pc_update, bus.branch, bus.ir_write, bus.reg_write, bus.mem_write};

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    ntotal++;
    assert (o === e) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, o, e);
  endtask

  function automatic bit is_legal(logic [6:0] op);
    return op == Lw || op == Sw || op == Rt || op == It || op == Jal || op == Beq;
  endfunction

  // Expected outputs per state code, straight from the per-state output table.
  function automatic logic [14:0] exp_ctrl(int s);
    logic pcu, br, irw, rw, mw, adr, ill;
    logic [1:0] a, b, aop, res;
    {pcu, br, irw, rw, mw, adr, ill} = '0;
    {a, b, aop, res} = '0;
    case (s)
      0:  begin irw = 1; pcu = 1; b = 2'b10; res = 2'b10; end
      1:  begin a = 2'b01; b = 2'b01; end
      2:  begin a = 2'b10; b = 2'b01; end
      3:  adr = 1;
      4:  begin res = 2'b01; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin a = 2'b10; aop = 2'b10; end
      7:  rw = 1;
      8:  begin a = 2'b10; b = 2'b01; aop = 2'b10; end
      9:  begin a = 2'b01; b = 2'b10; pcu = 1; end
      10: begin a = 2'b10; aop = 2'b01; br = 1; end
      11: ill = 1;
      default: ;
    endcase
    return {pcu, br, irw, rw, mw, adr, a, b, aop, res, ill};
  endfunction

  function automatic logic [1:0] exp_imm(logic [6:0] op);
    if (op == Sw) return 2'b01;
    if (op == Beq) return 2'b10;
    if (op == Jal) return 2'b11;
    return 2'b00;
  endfunction

  function automatic int seq_len(logic [6:0] op);
    if (op == Lw) return 5;
    if (op == Beq) return 3;
    if (is_legal(op)) return 4;
    return 2;
  endfunction

  function automatic int seq_at(logic [6:0] op, int i);
    int s[5];
    s = '{0, 1, 0, 0, 0};
    if (op == Lw) s = '{0, 1, 2, 3, 4};
    else if (op == Sw) s = '{0, 1, 2, 5, 0};
    else if (op == Rt) s = '{0, 1, 6, 7, 0};
    else if (op == It) s = '{0, 1, 8, 7, 0};
    else if (op == Jal) s = '{0, 1, 9, 7, 0};
    else if (op == Beq) s = '{0, 1, 10, 0, 0};
    return s[i];
  endfunction

  task automatic step(input logic rst, input logic [6:0] opv);
    @(negedge clk);
    reset  = rst;
    bus.op = opv;
    #1;
  endtask

  // op is only held valid where it is sampled; elsewhere it is randomised to prove it is ignored.
  task automatic run_instr(input logic [6:0] opv, input int abort_at);
    int n;
    bit mem;
    n = seq_len(opv);
    mem = (opv == Lw) || (opv == Sw);
    for (int i = 0; i < n; i++) begin
      logic [6:0] d;
      d = (i == 1 || (i == 2 && mem)) ? opv : 7'($urandom);
      if (i == abort_at) begin
        step(1'b1, d);
        check("abort_state", 32'(bus.state), 32'(seq_at(opv, i)));
        check("abort_strobes", 32'(strobes), 32'd0);
        return;
      end
      step(1'b0, d);
      check("state", 32'(bus.state), 32'(seq_at(opv, i)));
      check("ctrl", 32'(obs), 32'(exp_ctrl(seq_at(opv, i))));
      check("imm_src", 32'(bus.imm_src), 32'(exp_imm(d)));
    end
  endtask

  task automatic do_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 7'($urandom));
      check("reset_strobes", 32'(strobes), 32'd0);
      if (k > 0) begin
        check("reset_state", 32'(bus.state), 32'd0);
        check("reset_illegal", 32'(bus.illegal_op), 32'd0);
      end
    end
  endtask

  task automatic do_instr(input logic [6:0] opv);
    run_instr(opv, -1);
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    if (!is_legal(opv)) begin
      for (int k = 0; k < 10; k++) begin
        step(1'b0, 7'($urandom));
        check("trap_state", 32'(bus.state), 32'd11);
        check("trap_ctrl", 32'(obs), 32'(exp_ctrl(11)));
      end
      do_reset();
    end
`endif
  endtask

  initial begin
    logic [6:0] pool[6];
    logic [6:0] r;
    pool = '{Lw, Sw, Rt, It, Jal, Beq};
    reset  = 1'b1;
    bus.op = '0;

    do_reset();
    do_instr(Lw);
    do_instr(Sw);
    do_instr(Beq);
    do_instr(Jal);
    do_instr(Rt);
    do_instr(It);
    do_instr(7'b1111111);
    do_instr(Lw);

    // Abort lw in MEMREAD; reg_write must never pulse.
    run_instr(Lw, 3);
    step(1'b1, Lw);
    check("abort_next_state", 32'(bus.state), 32'd0);
    check("abort_next_strobes", 32'(strobes), 32'd0);
    do_instr(Lw);

    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 7) == 0) begin
        r = 7'($urandom);
        while (is_legal(r)) r = 7'($urandom);
      end else begin
        r = pool[$urandom_range(0, 5)];
      end
      do_instr(r);
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
